// File: rtl/rom_fetch_seq.sv
// Address sequencer for the 16-word instruction ROM with a 2-entry fall-through output buffer.
// Define FETCH_BREAKPOINT_EN to add the bp_en/bp_addr/bp_hit breakpoint ports.
module rom_fetch_seq #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int LAST_ADDR = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              bp_hit
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] buf0_data_q, buf0_data_d, buf1_data_q, buf1_data_d;
    logic [ADDR_W-1:0] buf0_addr_q, buf0_addr_d, buf1_addr_q, buf1_addr_d;

    logic              pop;
    logic              push;
    logic              start_ok;
    logic              room;
    logic              bp_match;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [2:0]        occupancy;
    logic [1:0]        level;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign instr_valid = (count_q != 2'd0);
    assign instr       = buf0_data_q;
    assign instr_addr  = buf0_addr_q;
    assign rom_addr    = rom_addr_q;
    assign busy        = (state_q != ST_IDLE);

    assign pop       = instr_valid & instr_ready;
    assign push      = inflight_q & ~jmp_valid;
    assign start_ok  = start & ~halt & ~jmp_valid;
    assign jmp_tgt   = (jmp_addr > LAST) ? LAST : jmp_addr;
    // Words already buffered plus the one still in the ROM, minus the one leaving this edge.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign room      = (occupancy < 3'd2);

`ifdef FETCH_BREAKPOINT_EN
    assign bp_match = bp_en & (pc_q == bp_addr);
`else
    assign bp_match = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rom_addr_d = rom_addr_q;
        inflight_d = 1'b0;
        issue      = 1'b0;
        issue_addr = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (jmp_valid) begin
                    pc_d = jmp_tgt;
                end else if (start_ok) begin
                    if (bp_match) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                        issue   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (jmp_valid) begin
                    pc_d = jmp_tgt;
                    if (halt) begin
                        state_d = ST_DRAIN;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = jmp_tgt;
                    end
                end else if (halt) begin
                    state_d = ST_DRAIN;
                end else if (room) begin
                    if (bp_match) begin
                        state_d = ST_DRAIN;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (jmp_valid) begin
                    pc_d = jmp_tgt;
                end
                if (!inflight_q && count_q == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            rom_addr_d = issue_addr;
            pc_d       = wrap_inc(issue_addr);
            inflight_d = 1'b1;
        end
    end

    // Pop shifts the tail forward; the incoming word lands in the first free slot after that.
    always_comb begin
        buf0_data_d = buf0_data_q;
        buf0_addr_d = buf0_addr_q;
        buf1_data_d = buf1_data_q;
        buf1_addr_d = buf1_addr_q;
        level       = count_q - {1'b0, pop};
        count_d     = level + {1'b0, push};
        if (pop) begin
            buf0_data_d = buf1_data_q;
            buf0_addr_d = buf1_addr_q;
        end
        if (push) begin
            if (level == 2'd0) begin
                buf0_data_d = rom_data;
                buf0_addr_d = rom_addr_q;
            end else begin
                buf1_data_d = rom_data;
                buf1_addr_d = rom_addr_q;
            end
        end
        if (jmp_valid) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            rom_addr_q  <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            buf0_data_q <= '0;
            buf0_addr_q <= '0;
            buf1_data_q <= '0;
            buf1_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rom_addr_q  <= rom_addr_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            buf0_data_q <= buf0_data_d;
            buf0_addr_q <= buf0_addr_d;
            buf1_data_q <= buf1_data_d;
            buf1_addr_q <= buf1_addr_d;
        end
    end

`ifdef FETCH_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;
    logic bp_set;

    // A fresh start or a jump clears the sticky flag, but a breakpoint hit on that same edge wins.
    always_comb begin
        bp_set   = bp_match & (((state_q == ST_IDLE) & start_ok)
                 | ((state_q == ST_RUN) & ~jmp_valid & ~halt & room));
        bp_hit_d = bp_hit_q;
        if (jmp_valid || (state_q == ST_IDLE && start_ok)) begin
            bp_hit_d = 1'b0;
        end
        if (bp_set) begin
            bp_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`endif

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Self-checking bench for rom_fetch_seq: vector table, directed corner sequences and a
// randomized run scored against an address-stream model. Breakpoint checks need FETCH_BREAKPOINT_EN.
module tb_rom_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        jmp_valid;
    logic [3:0]  jmp_addr;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [3:0]  instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
`ifdef FETCH_BREAKPOINT_EN
    logic        bp_en;
    logic [3:0]  bp_addr;
    logic        bp_hit;
`endif

    logic [15:0] rom_mem [16];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int s, h, j, ja, r;
        int ev, ea, eb, er;
    } vec_t;
    vec_t vecs[$];
    int   got[$];

    rom_fetch_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt       (halt),
        .jmp_valid  (jmp_valid),
        .jmp_addr   (jmp_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .busy       (busy)
`ifdef FETCH_BREAKPOINT_EN
        ,
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .bp_hit     (bp_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM behaviour: the word for the current address appears on the falling edge.
    always @(negedge clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int s, input int h, input int j, input int ja, input int r);
        start       = s[0];
        halt        = h[0];
        jmp_valid   = j[0];
        jmp_addr    = ja[3:0];
        instr_ready = r[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        if (instr_valid && instr_ready) begin
            got.push_back(int'(instr_addr));
            checkOutput("xfer_data", int'(instr), int'(rom_mem[instr_addr]));
        end
    endtask

    task automatic addVec(input int s, h, j, ja, r, ev, ea, eb, er);
        vec_t v;
        v = '{s, h, j, ja, r, ev, ea, eb, er};
        vecs.push_back(v);
    endtask

    initial begin
        int exp_addr;
        int exp_known;
        int n_xfer;
        int saw6;
        int rr, jj, ja;

        for (int k = 0; k < 16; k++) rom_mem[k] = 16'($urandom);
        rom_data = '0;
        rst_n    = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
`ifdef FETCH_BREAKPOINT_EN
        bp_en   = 1'b0;
        bp_addr = '0;
`endif

        //            s h j ja r   ev ea eb er
        addVec(1, 0, 0, 0,  1,  0, 0,  1, 0);
        addVec(0, 0, 0, 0,  1,  1, 0,  1, 1);
        addVec(0, 0, 0, 0,  1,  1, 1,  1, 2);
        addVec(0, 0, 0, 0,  1,  1, 2,  1, 3);
        addVec(0, 0, 0, 0,  1,  1, 3,  1, 4);
        for (int k = 0; k < 5; k++) addVec(0, 0, 0, 0, 0, 1, 3, 1, 4);
        addVec(0, 0, 0, 0,  1,  1, 4,  1, 5);
        addVec(0, 0, 0, 0,  1,  1, 5,  1, 6);
        addVec(0, 0, 0, 0,  1,  1, 6,  1, 7);
        addVec(0, 0, 0, 0,  0,  1, 6,  1, 7);
        addVec(0, 0, 1, 9,  0,  0, 0,  1, 9);
        addVec(0, 0, 0, 0,  1,  1, 9,  1, 10);
        addVec(0, 1, 0, 0,  1,  1, 10, 1, 10);
        addVec(0, 0, 0, 0,  1,  0, 0,  1, 10);
        addVec(0, 0, 0, 0,  1,  0, 0,  0, 10);
        addVec(1, 0, 0, 0,  1,  0, 0,  1, 11);
        addVec(0, 0, 0, 0,  1,  1, 11, 1, 12);
        addVec(0, 0, 1, 14, 1,  0, 0,  1, 14);
        addVec(0, 0, 0, 0,  1,  1, 14, 1, 15);
        addVec(0, 0, 0, 0,  1,  1, 15, 1, 0);
        addVec(0, 0, 0, 0,  1,  1, 0,  1, 1);
        addVec(0, 0, 0, 0,  1,  1, 1,  1, 2);
        addVec(1, 0, 0, 0,  1,  1, 2,  1, 3);

        #23;
        checkOutput("rst_valid", int'(instr_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_rom_addr", int'(rom_addr), 0);
        checkOutput("rst_instr", int'(instr), 0);
        checkOutput("rst_instr_addr", int'(instr_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("idle_busy", int'(busy), 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s, vecs[i].h, vecs[i].j, vecs[i].ja, vecs[i].r);
            step();
            checkOutput($sformatf("vec%0d_valid", i), int'(instr_valid), vecs[i].ev);
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), vecs[i].eb);
            checkOutput($sformatf("vec%0d_rom_addr", i), int'(rom_addr), vecs[i].er);
            if (vecs[i].ev != 0) begin
                checkOutput($sformatf("vec%0d_instr_addr", i), int'(instr_addr), vecs[i].ea);
                checkOutput($sformatf("vec%0d_instr", i), int'(instr), int'(rom_mem[vecs[i].ea]));
            end
        end

        // Halt with one word buffered and one still in the ROM, downstream stalled.
        applyStimulus(0, 1, 0, 0, 0);
        step();
        checkOutput("halt_busy", int'(busy), 1);
        checkOutput("halt_addr", int'(instr_addr), 2);
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("drain_valid", int'(instr_valid), 1);
        checkOutput("drain_addr", int'(instr_addr), 2);
        got.delete();
        applyStimulus(0, 0, 0, 0, 1);
        for (int c = 0; c < 10 && busy; c++) begin
            observe();
            step();
        end
        checkOutput("drain_count", got.size(), 2);
        for (int k = 0; k < got.size(); k++) checkOutput($sformatf("drain_word%0d", k), got[k], 2 + k);
        checkOutput("drain_end_busy", int'(busy), 0);
        checkOutput("drain_end_valid", int'(instr_valid), 0);
        applyStimulus(1, 0, 0, 0, 1);
        step();
        checkOutput("resume_rom_addr", int'(rom_addr), 4);
        checkOutput("resume_busy", int'(busy), 1);
        applyStimulus(0, 0, 0, 0, 1);
        step();
        checkOutput("resume_valid", int'(instr_valid), 1);
        checkOutput("resume_addr", int'(instr_addr), 4);

        // Jump together with halt flushes and drains straight to idle.
        applyStimulus(0, 1, 1, 7, 1);
        step();
        checkOutput("jh_valid", int'(instr_valid), 0);
        checkOutput("jh_busy", int'(busy), 1);
        applyStimulus(0, 0, 0, 0, 1);
        step();
        checkOutput("jh_idle_busy", int'(busy), 0);
        checkOutput("jh_idle_valid", int'(instr_valid), 0);
        applyStimulus(1, 1, 0, 0, 1);
        step();
        checkOutput("halt_beats_start", int'(busy), 0);
        applyStimulus(0, 0, 1, 12, 1);
        step();
        checkOutput("idle_jmp_busy", int'(busy), 0);
        checkOutput("idle_jmp_rom_addr", int'(rom_addr), 5);
        applyStimulus(1, 0, 0, 0, 1);
        step();
        checkOutput("jmp_start_rom_addr", int'(rom_addr), 12);
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("jmp_start_addr", int'(instr_addr), 12);
        checkOutput("jmp_start_instr", int'(instr), int'(rom_mem[12]));

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", int'(instr_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_rom_addr", int'(rom_addr), 0);
        checkOutput("midrst_instr", int'(instr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("postrst_busy", int'(busy), 0);

`ifdef FETCH_BREAKPOINT_EN
        bp_en   = 1'b1;
        bp_addr = 4'd6;
        got.delete();
        saw6 = 0;
        applyStimulus(1, 0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 1);
        for (int c = 0; c < 30 && busy; c++) begin
            observe();
            step();
            if (rom_addr == 4'd6) saw6 = 1;
        end
        checkOutput("bp_count", got.size(), 6);
        for (int k = 0; k < got.size(); k++) checkOutput($sformatf("bp_word%0d", k), got[k], k);
        checkOutput("bp_never_issued", saw6, 0);
        checkOutput("bp_hit", int'(bp_hit), 1);
        checkOutput("bp_idle", int'(busy), 0);
        bp_en = 1'b0;
        applyStimulus(1, 0, 0, 0, 1);
        step();
        checkOutput("bp_clear_on_start", int'(bp_hit), 0);
`endif

        // Randomized run: every transfer must follow the expected address stream.
        applyStimulus(1, 0, 0, 0, 1);
        step();
        exp_known = 0;
        exp_addr  = 0;
        n_xfer    = 0;
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 9) < 7) ? 1 : 0;
            jj = (i == 0 || $urandom_range(0, 19) == 0) ? 1 : 0;
            ja = int'($urandom_range(0, 15));
            applyStimulus(0, 0, jj, ja, rr);
            if (instr_valid && instr_ready) begin
                if (exp_known != 0) begin
                    checkOutput("rand_addr", int'(instr_addr), exp_addr);
                    n_xfer++;
                end
                checkOutput("rand_data", int'(instr), int'(rom_mem[instr_addr]));
                exp_addr = (exp_addr + 1) % 16;
            end
            if (jj != 0) begin
                exp_addr  = ja;
                exp_known = 1;
            end
            step();
        end
        checkOutput("rand_throughput", int'(n_xfer >= 100), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
